// File: rtl/mips_multicycle_control.sv
// Control unit for a multicycle MIPS datapath: Moore FSM sequencing lw, sw,
// R-type (add/sub/and/or/slt), beq, addi and j, with a sticky illegal-instruction flag.
module mips_multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [4:0]  ra,
    output logic [4:0]  rb,
    output logic [4:0]  rw,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  pc_src,
    output logic        pc_en,
    output logic [3:0]  state,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_RST    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     cur_state;
    state_t     nxt_state;
    logic       set_illegal;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_shamt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    assign ra    = instr[25:21];
    assign rb    = instr[20:16];
    assign rw    = reg_dst ? instr[15:11] : instr[20:16];
    assign state = cur_state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_RST;
            illegal   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        nxt_state   = S_FETCH;
        set_illegal = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl    = 3'b000;
        pc_src      = 2'b00;
        pc_en       = 1'b0;

        case (cur_state)
            S_RST: nxt_state = S_FETCH;
            S_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                pc_en     = 1'b1;
                nxt_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JUMP;
                    default: begin
                        nxt_state   = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                nxt_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                nxt_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                nxt_state = S_ALUWB;
                case (funct)
                    FN_ADD: alu_ctrl = ALU_ADD;
                    FN_SUB: alu_ctrl = ALU_SUB;
                    FN_AND: alu_ctrl = ALU_AND;
                    FN_OR:  alu_ctrl = ALU_OR;
                    FN_SLT: alu_ctrl = ALU_SLT;
                    default: begin
                        // Unknown funct: abandon the instruction before write-back.
                        alu_ctrl    = ALU_ADD;
                        set_illegal = 1'b1;
                        nxt_state   = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-instruction vector table,
// directed reset/illegal sequences, and randomized traffic against a path-based model.
module tb_mips_multicycle_control;

    typedef struct packed {
        logic [3:0] state;
        logic       illegal;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rw;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       pc_en;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        int          latency;
        int          writes;
        int          pc_loads;
        logic [4:0]  write_rw;
        logic        illegal_after;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic [4:0]  ra, rb, rw;
    logic        reg_write, reg_dst, mem_to_reg, iord, mem_write, ir_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_ctrl;
    logic        pc_en, illegal;
    logic [3:0]  state;
    outs_t       act;

    int n_tests = 0;
    int n_fail  = 0;

    int   exp_state;
    logic exp_ill;
    int   exp_path[$];

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
        .ra(ra), .rb(rb), .rw(rw),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .pc_en(pc_en), .state(state), .illegal(illegal)
    );

    always_comb act = {state, illegal, ra, rb, rw, reg_write, reg_dst, mem_to_reg, iord,
                       mem_write, ir_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en};

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic good_opcode(input logic [5:0] op);
        return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
    endfunction

    function automatic logic good_funct(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    // Expected outputs for one cycle, written from the per-state output rules.
    function automatic outs_t exp_out(input int st, input logic [31:0] ins, input logic z, input logic ill);
        outs_t o = '0;
        o.state   = 4'(st);
        o.illegal = ill;
        o.ra      = ins[25:21];
        o.rb      = ins[20:16];
        case (st)
            0:  begin o.ir_write = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010; o.pc_en = 1; end
            1:  begin o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; end
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
            3:  o.iord = 1;
            4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            5:  begin o.iord = 1; o.mem_write = 1; end
            6:  begin
                    o.alu_src_a = 1;
                    case (ins[5:0])
                        6'b100010: o.alu_ctrl = 3'b110;
                        6'b100100: o.alu_ctrl = 3'b000;
                        6'b100101: o.alu_ctrl = 3'b001;
                        6'b101010: o.alu_ctrl = 3'b111;
                        default:   o.alu_ctrl = 3'b010;
                    endcase
                end
            7:  begin o.reg_write = 1; o.reg_dst = 1; end
            8:  begin o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01; o.pc_en = z; end
            9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
            10: o.reg_write = 1;
            11: begin o.pc_src = 2'b10; o.pc_en = 1; end
            default: ;
        endcase
        o.rw = o.reg_dst ? ins[15:11] : ins[20:16];
        return o;
    endfunction

    // The model plans an instruction's whole state path when it leaves FETCH.
    task automatic model_advance(input logic r, input logic [31:0] ins);
        if (!r) begin
            exp_state = 15;
            exp_ill   = 1'b0;
            exp_path.delete();
        end else if (exp_state == 15) begin
            exp_state = 0;
        end else if (exp_state == 0) begin
            exp_path.delete();
            exp_path.push_back(1);
            case (ins[31:26])
                6'h23: begin exp_path.push_back(2); exp_path.push_back(3); exp_path.push_back(4); end
                6'h2B: begin exp_path.push_back(2); exp_path.push_back(5); end
                6'h00: begin exp_path.push_back(6); if (good_funct(ins[5:0])) exp_path.push_back(7); end
                6'h04: exp_path.push_back(8);
                6'h08: begin exp_path.push_back(9); exp_path.push_back(10); end
                6'h02: exp_path.push_back(11);
                default: ;
            endcase
            exp_state = exp_path.pop_front();
        end else begin
            if (exp_state == 1 && !good_opcode(ins[31:26])) exp_ill = 1'b1;
            if (exp_state == 6 && !good_funct(ins[5:0])) exp_ill = 1'b1;
            exp_state = (exp_path.size() > 0) ? exp_path.pop_front() : 0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  fl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[31:26] = 6'h23;
            1: r[31:26] = 6'h2B;
            2, 3: begin
                r[31:26] = 6'h00;
                if ($urandom_range(0, 4) != 0) r[5:0] = fl[$urandom_range(0, 4)];
            end
            4: r[31:26] = 6'h04;
            5: r[31:26] = 6'h08;
            6: r[31:26] = 6'h02;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   cyc, writes, pcl, wr_total;
        logic [4:0] wrw;
        int   trace[6] = '{0, 1, 2, 3, 4, 0};

        vecs[0] = '{"lw",       32'h8C220004, 1'b0, 5, 1, 1, 5'd2, 1'b0};
        vecs[1] = '{"sw",       32'hAC220004, 1'b0, 4, 0, 1, 5'd0, 1'b0};
        vecs[2] = '{"add",      32'h00430820, 1'b0, 4, 1, 1, 5'd1, 1'b0};
        vecs[3] = '{"sub",      32'h00430822, 1'b1, 4, 1, 1, 5'd1, 1'b0};
        vecs[4] = '{"addi",     32'h20450007, 1'b0, 4, 1, 1, 5'd5, 1'b0};
        vecs[5] = '{"beq_z1",   32'h10430003, 1'b1, 3, 0, 2, 5'd0, 1'b0};
        vecs[6] = '{"beq_z0",   32'h10430003, 1'b0, 3, 0, 1, 5'd0, 1'b0};
        vecs[7] = '{"j",        32'h08000010, 1'b0, 3, 0, 2, 5'd0, 1'b0};
        vecs[8] = '{"bad_op",   32'hFC000000, 1'b0, 2, 0, 1, 5'd0, 1'b1};
        vecs[9] = '{"bad_fn",   32'h00430800, 1'b0, 3, 0, 1, 5'd0, 1'b1};

        // Per-instruction vectors, each from a fresh reset.
        for (int v = 0; v < 10; v++) begin
            apply_reset();
            instr = vecs[v].instr;
            zero  = vecs[v].zero;
            #1;
            cyc = 0; writes = 0; pcl = 0; wrw = 5'd0;
            do begin
                if (reg_write) begin writes++; wrw = rw; end
                if (pc_en) pcl++;
                cyc++;
                step();
            end while (state != 4'd0 && cyc < 12);
            check({vecs[v].name, "_latency"}, 64'(cyc), 64'(vecs[v].latency));
            check({vecs[v].name, "_writes"}, 64'(writes), 64'(vecs[v].writes));
            check({vecs[v].name, "_pc_loads"}, 64'(pcl), 64'(vecs[v].pc_loads));
            check({vecs[v].name, "_rw"}, 64'(wrw), 64'(vecs[v].write_rw));
            check({vecs[v].name, "_illegal"}, 64'(illegal), 64'(vecs[v].illegal_after));
        end

        // Reset then lw: exact state trace and write-back cycle.
        rst_n = 1'b0; instr = 32'h8C220004; zero = 1'b0;
        step();
        check("rst_state", 64'(state), 64'd15);
        check("rst_strobes", 64'({pc_en, reg_write, mem_write, ir_write, illegal}), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("lw_trace_state", 64'(state), 64'(trace[i]));
            check("lw_trace_reg_write", 64'(reg_write), 64'(i == 4));
            if (i == 4) check("lw_wb_rw_m2r", 64'({rw, mem_to_reg}), 64'({5'd2, 1'b1}));
        end

        // add: EXEC alu_ctrl and ALUWB register selects.
        instr = 32'h00430820;
        step();
        check("add_decode", 64'(state), 64'd1);
        step();
        check("add_exec", 64'({state, alu_ctrl}), 64'({4'd6, 3'b010}));
        step();
        check("add_aluwb", 64'({state, reg_write, rw, ra, rb}), 64'({4'd7, 1'b1, 5'd1, 5'd2, 5'd3}));
        step();
        check("add_done", 64'(state), 64'd0);

        // beq taken then not taken; pc_en follows zero combinationally in BRANCH.
        wr_total = 0;
        instr = 32'h10430003; zero = 1'b1;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            if (reg_write) wr_total++;
            step();
            if (reg_write) wr_total++;
            step();
            if (reg_write) wr_total++;
            check("beq_branch", 64'({state, pc_en}), 64'({4'd8, (k == 0) ? 1'b1 : 1'b0}));
            zero = ~zero;
            #1;
            check("beq_pc_en_comb", 64'(pc_en), 64'(zero));
            step();
        end
        check("beq_no_write", 64'(wr_total), 64'd0);
        check("beq_done", 64'(state), 64'd0);

        // Illegal opcode: back to FETCH after DECODE, flag sticky across a valid add.
        instr = 32'hFC000000;
        step();
        check("ill_decode", 64'({state, illegal}), 64'({4'd1, 1'b0}));
        step();
        check("ill_fetch", 64'({state, illegal}), 64'({4'd0, 1'b1}));
        instr = 32'h00430820;
        for (int i = 0; i < 4; i++) step();
        check("ill_sticky", 64'({state, illegal}), 64'({4'd0, 1'b1}));

        // Reset asserted in MEMRD aborts lw and clears the flag.
        instr = 32'h8C220004;
        step(); step(); step();
        check("abort_memrd", 64'(state), 64'd3);
        rst_n = 1'b0;
        step();
        check("abort_rst", 64'({state, reg_write, illegal}), 64'({4'd15, 1'b0, 1'b0}));
        rst_n = 1'b1;
        step();
        check("abort_refetch", 64'({state, reg_write}), 64'({4'd0, 1'b0}));

        // Randomized traffic with occasional resets, against the path model.
        exp_state = 0;
        exp_ill   = 1'b0;
        exp_path.delete();
        for (int c = 0; c < 3000; c++) begin
            if (exp_state == 0) instr = rand_instr();
            zero  = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 49) != 0);
            #1;
            check("rand_outs", 64'(act), 64'(exp_out(exp_state, instr, zero, exp_ill)));
            model_advance(rst_n, instr);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 instr  input  32  current instruction from the instruction register; stable from the cycle after FETCH.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 ra  output  5  register-file read port A select, instr[25:21].
REQ-007 rb  output  5  register-file read port B select, instr[20:16].
REQ-008 rw  output  5  register-file write select: instr[15:11] when reg_dst=1, else instr[20:16].
REQ-009 reg_write  output  1  register-file write enable (AND-ed with the decoded rw inside the register file).
REQ-010 reg_dst, mem_to_reg, iord, mem_write, ir_write, alu_src_a  output  1 each  standard multicycle datapath selects and strobes.
REQ-011 alu_src_b  output  2  00=busB, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left by 2.
REQ-012 alu_ctrl  output  3  010=add, 110=sub, 000=and, 001=or, 111=slt.
REQ-013 pc_src  output  2  00=ALU result, 01=ALU output register, 10=jump target.
REQ-014 pc_en  output  1  PC load enable.
REQ-015 state  output  4  current state encoding, for debug.
REQ-016 illegal  output  1  sticky flag: an unsupported opcode or funct was decoded.

Function
REQ-017 States and encodings SHALL be: RST=15, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-018 Outputs SHALL be Moore, decoded from state only, except pc_en, rw, ra and rb.
REQ-019 Any output not named for a state SHALL be 0 in that state.
REQ-020 RST: all strobes SHALL be 0; next state SHALL be FETCH unconditionally.
REQ-021 FETCH: ir_write=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00, pc_en=1; next state DECODE.
REQ-022 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch-target precompute).
REQ-023 DECODE next state by opcode instr[31:26]:
  - 100011 (lw) and 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with illegal set.
REQ-024 MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=010; next MEMRD for lw, MEMWR for sw.
REQ-025 MEMRD: iord=1; next MEMWB.
REQ-026 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-027 MEMWR: iord=1, mem_write=1; next FETCH.
REQ-028 EXEC: alu_src_a=1, alu_src_b=00; alu_ctrl by funct instr[5:0]: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
REQ-029 EXEC with an unsupported funct: alu_ctrl=010, illegal set, next state FETCH (ALUWB skipped, no register write); otherwise next state ALUWB.
REQ-030 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-031 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01; pc_en SHALL equal zero combinationally; next FETCH.
REQ-032 ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=010; next ADDIWB.
REQ-033 ADDIWB: reg_write=1, reg_dst=0; next FETCH.
REQ-034 JUMP: pc_src=10, pc_en=1; next FETCH.
REQ-035 Instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; illegal 2 cycles.
REQ-036 reg_write SHALL be 1 in at most one cycle per instruction.
REQ-037 illegal SHALL stay set until reset.

Reset
REQ-038 When rst_n=0 at a rising edge: state<=RST and illegal<=0, overriding any in-flight transition in any state.
REQ-039 While in RST, pc_en, reg_write, mem_write and ir_write SHALL all be 0.
REQ-040 Deasserting rst_n mid-instruction SHALL restart from FETCH one cycle later; the aborted instruction SHALL cause no write.

Verification
REQ-041 Reset then lw (instr=0x8C220004) -> states RST,0,1,2,3,4,0; reg_write=1 only in MEMWB, with rw=2 and mem_to_reg=1.
REQ-042 add (instr=0x00430820) -> states 0,1,6,7; alu_ctrl=010 in EXEC; ALUWB shows reg_write=1, rw=1, ra=2, rb=3.
REQ-043 beq with zero=1, then again with zero=0 -> pc_en=1 in BRANCH for the first and 0 for the second; reg_write=0 throughout both.
REQ-044 opcode 111111 -> DECODE returns to FETCH, illegal=1 and stays 1 across the following valid instruction; R-type with funct 000000 also sets illegal and produces no reg_write.
REQ-045 rst_n=0 asserted in MEMRD -> next state RST, no reg_write; first FETCH follows one cycle after rst_n returns to 1.
